// File: rtl/ysyx_25020032_trap_ctrl_if.sv
// Commit / CSR-file / redirect bundle for the trap sequencer.
// slave = the trap controller, master = its surroundings.
interface ysyx_25020032_trap_ctrl_if;
  logic        cmt_valid;
  logic        cmt_ready;
  logic [31:0] cmt_pc;
  logic        cmt_illegal;
  logic        cmt_ecall;
  logic        cmt_mret;
  logic        cmt_csr_wen;
  logic [31:0] cmt_csr_addr;
  logic [31:0] cmt_csr_wdata;
  logic        irq_timer;
  logic [31:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic        exception;
  logic [31:0] exception_pc;
  logic [31:0] exception_cause;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        redir_valid;
  logic        redir_ready;
  logic [31:0] redir_pc;
  logic        busy;

  modport slave (
    input  cmt_valid, cmt_pc, cmt_illegal, cmt_ecall, cmt_mret,
           cmt_csr_wen, cmt_csr_addr, cmt_csr_wdata, irq_timer,
           mtvec, mepc, redir_ready,
    output cmt_ready, csr_addr, csr_wdata, csr_wen, exception,
           exception_pc, exception_cause, redir_valid, redir_pc, busy
  );

  modport master (
    output cmt_valid, cmt_pc, cmt_illegal, cmt_ecall, cmt_mret,
           cmt_csr_wen, cmt_csr_addr, cmt_csr_wdata, irq_timer,
           mtvec, mepc, redir_ready,
    input  cmt_ready, csr_addr, csr_wdata, csr_wen, exception,
           exception_pc, exception_cause, redir_valid, redir_pc, busy
  );
endinterface

// File: rtl/ysyx_25020032_trap_ctrl.sv
// Trap/return sequencer: commit event -> one-cycle CSR exception write -> PC redirect.
// Optional machine timer interrupt path enabled by defining YSYX_25020032_TIMER_IRQ_EN.
module ysyx_25020032_trap_ctrl #(
  parameter logic [31:0] CAUSE_ILLEGAL = 32'd2,
  parameter logic [31:0] CAUSE_ECALL   = 32'd11,
  parameter logic [31:0] CAUSE_IRQ     = 32'h8000_0007
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_25020032_trap_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    TRAP       = 2'd1,
    REDIR_TRAP = 2'd2,
    REDIR_MRET = 2'd3
  } state_t;

  state_t      state_r;
  logic        exc_r;
  logic [31:0] exc_pc_r;
  logic [31:0] exc_cause_r;
  logic        redir_valid_r;
  logic        busy_r;
  logic        cmt_ready_r;

  logic        accept_s;
  logic        irq_take_s;
  logic        trap_take_s;
  logic        mret_take_s;
  logic        csr_pass_s;
  logic [31:0] trap_cause_s;
  logic [31:0] redir_pc_s;

  assign accept_s = (state_r == IDLE) & bus.cmt_valid;

`ifdef YSYX_25020032_TIMER_IRQ_EN
  assign irq_take_s = accept_s & bus.irq_timer;
`else
  logic unused_irq_s;
  assign unused_irq_s = bus.irq_timer;
  assign irq_take_s   = 1'b0;
`endif

  // Commit decode: the highest-priority event wins, everything below it is squashed
  always_comb begin
    trap_take_s  = 1'b0;
    mret_take_s  = 1'b0;
    csr_pass_s   = 1'b0;
    trap_cause_s = CAUSE_ILLEGAL;
    if (!accept_s) begin
      csr_pass_s = 1'b0;
    end else if (irq_take_s) begin
      trap_take_s  = 1'b1;
      trap_cause_s = CAUSE_IRQ;
    end else if (bus.cmt_illegal) begin
      trap_take_s  = 1'b1;
      trap_cause_s = CAUSE_ILLEGAL;
    end else if (bus.cmt_ecall) begin
      trap_take_s  = 1'b1;
      trap_cause_s = CAUSE_ECALL;
    end else if (bus.cmt_mret) begin
      mret_take_s = 1'b1;
    end else if (bus.cmt_csr_wen) begin
      csr_pass_s = 1'b1;
    end else begin
      csr_pass_s = 1'b0;
    end
  end

  // Redirect target follows the CSR file directly; nothing writes it while redirecting
  always_comb begin
    case (state_r)
      REDIR_TRAP: redir_pc_s = bus.mtvec;
      REDIR_MRET: redir_pc_s = bus.mepc;
      default:    redir_pc_s = 32'd0;
    endcase
  end

  // Sequencer state and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      exc_r         <= 1'b0;
      exc_pc_r      <= 32'd0;
      exc_cause_r   <= 32'd0;
      redir_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      cmt_ready_r   <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (trap_take_s) begin
            state_r     <= TRAP;
            exc_r       <= 1'b1;
            exc_pc_r    <= bus.cmt_pc;
            exc_cause_r <= trap_cause_s;
            busy_r      <= 1'b1;
            cmt_ready_r <= 1'b0;
          end else if (mret_take_s) begin
            state_r       <= REDIR_MRET;
            redir_valid_r <= 1'b1;
            busy_r        <= 1'b1;
            cmt_ready_r   <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        TRAP: begin
          state_r       <= REDIR_TRAP;
          exc_r         <= 1'b0;
          redir_valid_r <= 1'b1;
        end
        REDIR_TRAP, REDIR_MRET: begin
          if (bus.redir_ready) begin
            state_r       <= IDLE;
            redir_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            cmt_ready_r   <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r       <= IDLE;
          exc_r         <= 1'b0;
          redir_valid_r <= 1'b0;
          busy_r        <= 1'b0;
          cmt_ready_r   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmt_ready       = cmt_ready_r;
  assign bus.busy            = busy_r;
  assign bus.exception       = exc_r;
  assign bus.exception_pc    = exc_pc_r;
  assign bus.exception_cause = exc_cause_r;
  assign bus.redir_valid     = redir_valid_r;
  assign bus.redir_pc        = redir_pc_s;
  assign bus.csr_wen         = csr_pass_s;
  assign bus.csr_addr        = bus.cmt_csr_addr;
  assign bus.csr_wdata       = bus.cmt_csr_wdata;

endmodule

// File: tb/tb_ysyx_25020032_trap_ctrl.sv
// Directed plus randomized bench for the trap sequencer against an event-level model.
module tb_ysyx_25020032_trap_ctrl;
`ifdef YSYX_25020032_TIMER_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_25020032_trap_ctrl_if bus();
  ysyx_25020032_trap_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Model: an exception cycle pending, a redirect pending (and which kind), latched trap info
  bit          m_exc;
  bit          m_redir;
  bit          m_is_mret;
  logic [31:0] m_epc;
  logic [31:0] m_cause;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_exc = 1'b0; m_redir = 1'b0; m_is_mret = 1'b0;
    m_epc = 32'd0; m_cause = 32'd0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (m_exc) begin
      m_exc = 1'b0; m_redir = 1'b1; m_is_mret = 1'b0;
    end else if (m_redir) begin
      if (bus.redir_ready) m_redir = 1'b0;
    end else if (bus.cmt_valid) begin
      if (IRQ_EN && bus.irq_timer) begin
        m_exc = 1'b1; m_epc = bus.cmt_pc; m_cause = 32'h8000_0007;
      end else if (bus.cmt_illegal) begin
        m_exc = 1'b1; m_epc = bus.cmt_pc; m_cause = 32'd2;
      end else if (bus.cmt_ecall) begin
        m_exc = 1'b1; m_epc = bus.cmt_pc; m_cause = 32'd11;
      end else if (bus.cmt_mret) begin
        m_redir = 1'b1; m_is_mret = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    bit idle, exp_wen;
    idle    = !m_exc && !m_redir;
    exp_wen = idle && bus.cmt_valid && bus.cmt_csr_wen && !(IRQ_EN && bus.irq_timer)
              && !bus.cmt_illegal && !bus.cmt_ecall && !bus.cmt_mret;
    chk("cmt_ready", 32'(bus.cmt_ready), 32'(idle));
    chk("busy", 32'(bus.busy), 32'(!idle));
    chk("exception", 32'(bus.exception), 32'(m_exc));
    chk("exception_pc", bus.exception_pc, m_epc);
    chk("exception_cause", bus.exception_cause, m_cause);
    chk("redir_valid", 32'(bus.redir_valid), 32'(m_redir));
    chk("csr_wen", 32'(bus.csr_wen), 32'(exp_wen));
    if (m_redir) chk("redir_pc", bus.redir_pc, m_is_mret ? bus.mepc : bus.mtvec);
    if (idle) chk("csr_addr", bus.csr_addr, bus.cmt_csr_addr);
    if (exp_wen) chk("csr_wdata", bus.csr_wdata, bus.cmt_csr_wdata);
  endtask

  task automatic settle();
    #1;
    check_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.cmt_valid = 1'b0; bus.cmt_pc = 32'd0; bus.cmt_illegal = 1'b0;
    bus.cmt_ecall = 1'b0; bus.cmt_mret = 1'b0; bus.cmt_csr_wen = 1'b0;
    bus.cmt_csr_addr = 32'd0; bus.cmt_csr_wdata = 32'd0; bus.irq_timer = 1'b0;
    bus.redir_ready = 1'b1;
  endtask

  task automatic commit(input logic [31:0] pc, input bit ill, input bit ec, input bit mr,
                        input bit cw, input logic [31:0] addr, input logic [31:0] data,
                        input bit irq);
    bus.cmt_valid = 1'b1; bus.cmt_pc = pc; bus.cmt_illegal = ill; bus.cmt_ecall = ec;
    bus.cmt_mret = mr; bus.cmt_csr_wen = cw; bus.cmt_csr_addr = addr;
    bus.cmt_csr_wdata = data; bus.irq_timer = irq;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.mtvec = 32'h8000_0100;
    bus.mepc  = 32'h8000_0014;
    model_reset();
    @(negedge clk);
    settle();
    tick();
    rst = 1'b0;
    settle();
    tick();

    // ecall: exception one cycle later, then redirect to mtvec
    commit(32'h8000_0010, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    settle(); tick();
    idle_inputs();
    settle();
    chk("t2_exc", 32'(bus.exception), 32'd1);
    chk("t2_pc", bus.exception_pc, 32'h8000_0010);
    chk("t2_cause", bus.exception_cause, 32'd11);
    tick();
    settle();
    chk("t2_redir", 32'(bus.redir_valid), 32'd1);
    chk("t2_target", bus.redir_pc, 32'h8000_0100);
    tick();
    settle(); tick();

    // mret with a stalled IFU: redirect held until the handshake
    commit(32'h8000_0030, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    settle(); tick();
    idle_inputs();
    bus.redir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t3_hold_valid", 32'(bus.redir_valid), 32'd1);
      chk("t3_hold_pc", bus.redir_pc, 32'h8000_0014);
      tick();
    end
    bus.redir_ready = 1'b1;
    settle(); tick();
    settle();
    chk("t3_idle", 32'(bus.cmt_ready), 32'd1);
    tick();

    // plain CSR write passes straight through
    commit(32'h8000_0034, 1'b0, 1'b0, 1'b0, 1'b1, 32'h305, 32'h1234, 1'b0);
    settle();
    chk("t4_wen", 32'(bus.csr_wen), 32'd1);
    chk("t4_addr", bus.csr_addr, 32'h305);
    chk("t4_wdata", bus.csr_wdata, 32'h1234);
    tick();
    idle_inputs();
    settle();
    chk("t4_busy", 32'(bus.busy), 32'd0);
    tick();

    // illegal beats ecall beats csr write
    commit(32'h8000_0040, 1'b1, 1'b1, 1'b0, 1'b1, 32'h341, 32'hdead, 1'b0);
    settle();
    chk("t5_wen", 32'(bus.csr_wen), 32'd0);
    tick();
    idle_inputs();
    settle();
    chk("t5_cause", bus.exception_cause, 32'd2);
    tick();
    settle(); tick();
    settle(); tick();

    // timer interrupt squashes a csr write only when the interrupt path exists
    commit(32'h8000_0020, 1'b0, 1'b0, 1'b0, 1'b1, 32'h305, 32'h55, 1'b1);
    settle();
    chk("t6_wen", 32'(bus.csr_wen), IRQ_EN ? 32'd0 : 32'd1);
    tick();
    idle_inputs();
    settle();
    chk("t6_exc", 32'(bus.exception), 32'(IRQ_EN));
    chk("t6_cause", bus.exception_cause, IRQ_EN ? 32'h8000_0007 : 32'd2);
    chk("t6_pc", bus.exception_pc, IRQ_EN ? 32'h8000_0020 : 32'h8000_0040);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
    end
    tick();

    // reset while a trap redirect is waiting
    commit(32'h8000_0050, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    settle(); tick();
    idle_inputs();
    bus.redir_ready = 1'b0;
    settle(); tick();
    settle();
    chk("t1_pre_redir", 32'(bus.redir_valid), 32'd1);
    rst = 1'b1;
    model_reset();
    settle();
    chk("t1_redir", 32'(bus.redir_valid), 32'd0);
    chk("t1_exc", 32'(bus.exception), 32'd0);
    chk("t1_ready", 32'(bus.cmt_ready), 32'd1);
    tick();
    rst = 1'b0;
    bus.redir_ready = 1'b1;
    settle(); tick();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(80) == 0);
      if (rst) begin
        model_reset();
        idle_inputs();
      end else begin
        bus.cmt_valid     = ($urandom_range(1) == 0);
        bus.cmt_pc        = $urandom;
        bus.cmt_illegal   = ($urandom_range(4) == 0);
        bus.cmt_ecall     = ($urandom_range(4) == 0);
        bus.cmt_mret      = ($urandom_range(3) == 0);
        bus.cmt_csr_wen   = ($urandom_range(1) == 0);
        bus.cmt_csr_addr  = 32'($urandom_range(4095));
        bus.cmt_csr_wdata = $urandom;
        bus.irq_timer     = ($urandom_range(3) == 0);
      end
      bus.redir_ready = ($urandom_range(2) != 0);
      if ($urandom_range(7) == 0) begin
        bus.mtvec = $urandom;
        bus.mepc  = $urandom;
      end
      settle();
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
